// File: rtl/tl_monitor.sv
// Traffic-light sequence monitor: locks onto the lamp sequence at RED, then checks phase order
// and phase lengths, counting completed light cycles and flagging errors.
module tl_monitor #(
  parameter int unsigned T_RED    = 3,
  parameter int unsigned T_RY     = 6,
  parameter int unsigned T_GREEN  = 3,
  parameter int unsigned T_YELLOW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [2:0] led,
  input  logic       err_clr,
  output logic [1:0] phase,
  output logic       locked,
  output logic [7:0] dur_cnt,
  output logic [7:0] cycles,
  output logic       err_seq,
  output logic       err_dur,
  output logic       err_pulse
);

  typedef enum logic {StSync, StTrack} state_e;

  localparam logic [1:0] PhRed    = 2'd0;
  localparam logic [1:0] PhRy     = 2'd1;
  localparam logic [1:0] PhGreen  = 2'd2;
  localparam logic [1:0] PhYellow = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] dur_q, dur_d;
  logic [7:0] cycles_q, cycles_d;
  logic       first_q, first_d;
  logic       seq_q, seq_d;
  logic       derr_q, derr_d;
  logic       pulse_q, pulse_d;

  logic       samp_legal;
  logic [1:0] samp_phase;
  logic [7:0] exp_len;
  logic       new_seq, new_dur;

  always_comb begin
    samp_legal = 1'b1;
    samp_phase = PhRed;
    case (led)
      3'b100:  samp_phase = PhRed;
      3'b110:  samp_phase = PhRy;
      3'b001:  samp_phase = PhGreen;
      3'b010:  samp_phase = PhYellow;
      default: samp_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (phase_q)
      PhRed:   exp_len = 8'(T_RED);
      PhRy:    exp_len = 8'(T_RY);
      PhGreen: exp_len = 8'(T_GREEN);
      default: exp_len = 8'(T_YELLOW);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dur_d    = dur_q;
    cycles_d = cycles_q;
    first_d  = first_q;
    new_seq  = 1'b0;
    new_dur  = 1'b0;
    if (ce) begin
      case (state_q)
        StSync: begin
          if (samp_legal && samp_phase == PhRed) begin
            state_d = StTrack;
            phase_d = PhRed;
            dur_d   = 8'd1;
            first_d = 1'b1;
          end
        end
        default: begin
          if (!samp_legal) begin
            new_seq = 1'b1;
            state_d = StSync;
          end else if (samp_phase == phase_q) begin
            if (dur_q != 8'hff) dur_d = dur_q + 8'd1;
          end else if (samp_phase == phase_q + 2'd1) begin
            // The phase entered at lock time is partial, so its length is not judged.
            new_dur = !first_q && (dur_q != exp_len);
            if (phase_q == PhYellow) cycles_d = cycles_q + 8'd1;
            phase_d = samp_phase;
            dur_d   = 8'd1;
            first_d = 1'b0;
          end else begin
            new_seq = 1'b1;
            state_d = StSync;
          end
        end
      endcase
    end
  end

  // A new error beats a simultaneous clear; a clear re-arms the pulse for that flag type.
  always_comb begin
    seq_d   = (err_clr ? 1'b0 : seq_q) | new_seq;
    derr_d  = (err_clr ? 1'b0 : derr_q) | new_dur;
    pulse_d = (new_seq && (!seq_q || err_clr)) || (new_dur && (!derr_q || err_clr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSync;
      phase_q  <= PhRed;
      dur_q    <= 8'd0;
      cycles_q <= 8'd0;
      first_q  <= 1'b1;
      seq_q    <= 1'b0;
      derr_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dur_q    <= dur_d;
      cycles_q <= cycles_d;
      first_q  <= first_d;
      seq_q    <= seq_d;
      derr_q   <= derr_d;
      pulse_q  <= pulse_d;
    end
  end

  assign phase     = phase_q;
  assign locked    = (state_q == StTrack);
  assign dur_cnt   = dur_q;
  assign cycles    = cycles_q;
  assign err_seq   = seq_q;
  assign err_dur   = derr_q;
  assign err_pulse = pulse_q;

endmodule
